risc_core_mc: RTL
=================

# risc_core_mc

Parametrised multi-cycle successor of the single-cycle 16-bit RISC top level. It sequences fetch, execute, memory and writeback through an explicit state machine and uses a wait-state data-memory handshake instead of a zero-latency RAM. Data width, PC width and register count are parameters. Instruction memory stays external, read combinationally; data memory is external behind a req/ack port.

## Interface
- DATA_W, 16, datapath/register width (≥8)
- PC_W, 6, PC and instruction-address width
- REG_N, 16, number of GPRs (power of 2, ≤16); R0 reads as 0, writes to R0 discarded
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- IMEM_ADDR  out  PC_W  fetch address (= PC)
- IMEM_RDATA  in  24  instruction word, valid combinationally from IMEM_ADDR
- DMEM_REQ  out  1  data access request, held until ack
- DMEM_WE  out  1  1 = store, 0 = load; valid while DMEM_REQ
- DMEM_ADDR  out  DATA_W  byte-agnostic word address
- DMEM_WDATA  out  DATA_W  store data
- DMEM_RDATA  in  DATA_W  load data, sampled in ack cycle
- DMEM_ACK  in  1  access complete this cycle
- STATUS_FLAG  out  3  {carry, zero, parity}, registered
- ALU_RES  out  DATA_W  last ALU result, registered
- HALTED  out  1  core in HALT
- ILLEGAL  out  1  sticky: illegal opcode executed

## Operation
- Word: op[23:20], rd[19:16], ra[15:12], rb[11:8], imm8[7:0]. Register indices use low log2(REG_N) bits.
- 0 ADD, 1 SUB (ra−rb), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical; amount = rb value low log2(DATA_W) bits): rd ← result; flags updated.
- 7 LDI: rd ← zero-extended imm8. 8 LD: rd ← mem[ra+imm8]. 9 ST: mem[ra+imm8] ← rb. Address add modulo 2^DATA_W.
- A JMP: PC ← imm8[PC_W−1:0]. B JZ: jump if zero flag = 1, else PC+1. C NOP. F HALT.
- D: MUL when RISC_CORE_MUL_EN is defined, else illegal. E: illegal → behaves as NOP, ILLEGAL set.
- Flags: ADD carry = bit DATA_W; SUB carry = borrow (ra<rb); logic ops carry = 0; SHL carry = last bit shifted out (0 for amount 0); SHR carry = 0. zero = (result==0); parity = XOR-reduce(result). Non-ALU opcodes leave flags and ALU_RES unchanged.
- States: FETCH → EXEC → {WB | MEM | FETCH | HALT}; MEM → WB (load) or FETCH (store) on DMEM_ACK; WB → FETCH.
- FETCH: IR ← IMEM_RDATA. EXEC: ALU evaluate, branch resolve, PC update, or issue memory request. WB: register write.
- PC increments modulo 2^PC_W (wraps 2^PC_W−1 → 0).
- HALT: absorbing; only RESET exits.

## Timing
- Reset (async assert, sync release): PC=0, state FETCH, all GPRs 0, STATUS_FLAG=0, ALU_RES=0, IR=0, DMEM_REQ=0, DMEM_WE=0, DMEM_ADDR=0, DMEM_WDATA=0, HALTED=0, ILLEGAL=0.
- ALU/LDI/MUL: 3 cycles. JMP/JZ/NOP/illegal: 2 cycles. LD: 3 + wait cycles (min 4 with ack in first MEM cycle). ST: 2 + wait cycles (min 3).
- DMEM_REQ rises on the EXEC→MEM edge; address/data/WE stable until the cycle DMEM_ACK=1 is sampled; REQ low the following cycle. ACK outside MEM ignored.
- Result write and flag update become visible on the edge leaving WB; next instruction reads updated registers.
- RESET mid-access drops DMEM_REQ immediately; no register write occurs.
- HALTED asserts on the EXEC→HALT edge.

## Configuration
- RISC_CORE_MUL_EN defined: opcode D = MUL, rd ← low DATA_W bits of ra×rb; carry = OR of high DATA_W bits; zero/parity from low bits; 3 cycles.
- Undefined: opcode D illegal (NOP + ILLEGAL); no multiplier synthesised.

## Test plan
- Reset then LDI R1,0xFF; LDI R2,0x01; ADD R3,R1,R2 → R3=0x0100, STATUS_FLAG=3'b001, ALU_RES=0x0100, PC=3 after 9 cycles.
- LDI R1,5; SUB R2,R1,R1; JZ 0x10 → taken, PC=0x10, zero=1; repeat with SUB R2,R1,R0 → not taken, PC advances by 1.
- ST R2 → mem[R1+4] with ACK delayed 3 cycles → REQ=1, WE=1, ADDR/WDATA stable 3 cycles, drops next; LD back → value in rd.
- PC at 63 executing NOP (PC_W=6) → PC wraps to 0; ADD writing R0 → R0 still reads 0.
- Opcode E → ILLEGAL=1, stays 1 through later instructions; opcode D without macro identical; with macro 0x0300×0x0100 → 0x0000, carry=1, zero=1.
- HALT → HALTED=1, PC frozen, no DMEM_REQ; RESET low during LD wait → REQ=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/risc_core_mc_if.sv
// Purpose : fetch and data-memory bus of the multi-cycle RISC core.
// Latency : fetch is combinational; a data access takes one or more cycles.
// Backpressure: memory stalls the core by withholding dmem_ack while dmem_req is high.
//
// Signals:
//   imem_addr  (core->mem)  fetch address, equal to PC
//   imem_rdata (mem->core)  24-bit instruction, valid combinationally from imem_addr
//   dmem_req   (core->mem)  access request, held until the ack cycle
//   dmem_we    (core->mem)  1 = store, 0 = load; valid while dmem_req
//   dmem_addr  (core->mem)  word address
//   dmem_wdata (core->mem)  store data
//   dmem_rdata (mem->core)  load data, sampled in the ack cycle
//   dmem_ack   (mem->core)  access completes this cycle
interface risc_core_mc_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 6
);
  logic [PC_W-1:0]   imem_addr;
  logic [23:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/risc_core_mc.sv
// Purpose : multi-cycle RISC core, FETCH -> EXEC -> {WB | MEM | FETCH | HALT}.
// Latency : ALU/LDI/MUL 3 cycles, JMP/JZ/NOP/illegal 2, LD 4+waits, ST 3+waits.
// Backpressure: core parks in MEM with dmem_req held until dmem_ack is seen.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   bus            risc_core_mc_if.master: instruction fetch and data memory
//   status_flag_o  registered {carry, zero, parity}
//   alu_res_o      registered result of the last ALU/MUL instruction
//   halted_o       core sits in HALT (left only by reset)
//   illegal_o      sticky, set once an illegal opcode has executed
// Optional feature: define RISC_CORE_MUL_EN to make opcode D a multiply;
// otherwise opcode D is treated as illegal and no multiplier is built.
module risc_core_mc #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 6,
  parameter int REG_N  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  risc_core_mc_if.master    bus,
  output logic [2:0]        status_flag_o,
  output logic [DATA_W-1:0] alu_res_o,
  output logic              halted_o,
  output logic              illegal_o
);

  localparam int RIDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;
  localparam int SH_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'hC;
`ifdef RISC_CORE_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hD;
`endif
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [23:0]       ir_q, ir_d;
  logic [DATA_W-1:0] gpr_q [REG_N];
  logic [DATA_W-1:0] gpr_d [REG_N];
  logic [2:0]        flag_q, flag_d;
  logic [2:0]        pflag_q, pflag_d;   // flags computed in EXEC, committed in WB
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] res_q, res_d;       // value waiting for the WB register write
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ill_q, ill_d;

  // Instruction fields; only the low RIDX_W bits of each register field matter.
  logic [3:0]        opcode;
  logic [RIDX_W-1:0] rd_idx, ra_idx, rb_idx;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] ra_val, rb_val;
  logic [SH_W-1:0]   sh_amt;

  assign opcode = ir_q[23:20];
  assign rd_idx = ir_q[16 +: RIDX_W];
  assign ra_idx = ir_q[12 +: RIDX_W];
  assign rb_idx = ir_q[8 +: RIDX_W];
  assign imm8   = ir_q[7:0];
  // gpr_q[0] is never written, so R0 reads as zero without a special case.
  assign ra_val = gpr_q[ra_idx];
  assign rb_val = gpr_q[rb_idx];
  assign sh_amt = rb_val[SH_W-1:0];

  // ALU: alu_hit marks opcodes that write rd and update flags/ALU_RES.
  logic              alu_hit;
  logic              alu_c;
  logic [DATA_W-1:0] alu_r;
`ifdef RISC_CORE_MUL_EN
  logic [2*DATA_W-1:0] mul_p;
`endif

  always_comb begin
    alu_hit = 1'b1;
    alu_c   = 1'b0;
    alu_r   = '0;
`ifdef RISC_CORE_MUL_EN
    mul_p   = '0;
`endif
    case (opcode)
      OP_ADD: {alu_c, alu_r} = {1'b0, ra_val} + {1'b0, rb_val};
      // Top bit of the widened difference is the borrow (ra < rb).
      OP_SUB: {alu_c, alu_r} = {1'b0, ra_val} - {1'b0, rb_val};
      OP_AND: alu_r = ra_val & rb_val;
      OP_OR:  alu_r = ra_val | rb_val;
      OP_XOR: alu_r = ra_val ^ rb_val;
      // Bit DATA_W of the widened shift is the last bit shifted out (0 for amount 0).
      OP_SHL: {alu_c, alu_r} = {1'b0, ra_val} << sh_amt;
      OP_SHR: alu_r = ra_val >> sh_amt;
`ifdef RISC_CORE_MUL_EN
      OP_MUL: begin
        mul_p = {{DATA_W{1'b0}}, ra_val} * {{DATA_W{1'b0}}, rb_val};
        alu_r = mul_p[DATA_W-1:0];
        alu_c = |mul_p[2*DATA_W-1:DATA_W];
      end
`endif
      default: alu_hit = 1'b0;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    gpr_d   = gpr_q;
    flag_d  = flag_q;
    pflag_d = pflag_q;
    alu_d   = alu_q;
    res_d   = res_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ill_d   = ill_q;

    case (state_q)
      S_FETCH: begin
        ir_d    = bus.imem_rdata;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        pc_d = pc_q + PC_W'(1);
        if (alu_hit) begin
          res_d   = alu_r;
          pflag_d = {alu_c, ~|alu_r, ^alu_r};
          state_d = S_WB;
        end else begin
          case (opcode)
            OP_LDI: begin
              res_d   = DATA_W'(imm8);
              state_d = S_WB;
            end
            OP_LD, OP_ST: begin
              req_d   = 1'b1;
              we_d    = (opcode == OP_ST);
              addr_d  = ra_val + DATA_W'(imm8);
              wdata_d = rb_val;
              state_d = S_MEM;
            end
            OP_JMP: begin
              pc_d    = PC_W'(imm8);
              state_d = S_FETCH;
            end
            OP_JZ: begin
              if (flag_q[1]) pc_d = PC_W'(imm8);
              state_d = S_FETCH;
            end
            OP_NOP: state_d = S_FETCH;
            OP_HALT: begin
              pc_d    = pc_q;
              state_d = S_HALT;
            end
            default: begin
              // Unassigned opcodes retire as NOP and latch the sticky flag.
              ill_d   = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
      end

      S_MEM: begin
        // Address/data/WE stay registered; only REQ falls after the ack.
        if (bus.dmem_ack) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = S_FETCH;
          end else begin
            res_d   = bus.dmem_rdata;
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        if (rd_idx != '0) gpr_d[rd_idx] = res_q;
        // IR is unchanged since EXEC, so alu_hit still identifies ALU ops.
        if (alu_hit) begin
          flag_d = pflag_q;
          alu_d  = res_q;
        end
        state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      for (int i = 0; i < REG_N; i++) gpr_q[i] <= '0;
      flag_q  <= '0;
      pflag_q <= '0;
      alu_q   <= '0;
      res_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      gpr_q   <= gpr_d;
      flag_q  <= flag_d;
      pflag_q <= pflag_d;
      alu_q   <= alu_d;
      res_q   <= res_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign status_flag_o  = flag_q;
  assign alu_res_o      = alu_q;
  assign halted_o       = (state_q == S_HALT);
  assign illegal_o      = ill_q;

endmodule
